// File: rtl/div_issue_pkg.sv
// Shared types for the EX-stage divide initiator: funct3 codes, one-hot FSM
// states, bus widths, watchdog default and the result-cache entry layout.
package div_issue_pkg;

  localparam int REG_W           = 32;
  localparam int ADDR_W          = 5;
  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [2:0]       op;
    logic [REG_W-1:0] res;
    logic             valid;
  } cache_entry_t;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

endpackage

// File: rtl/div_issue_result_cache.sv
// Single-entry memo of the last completed divide; looked up with the raw EX
// operands and refilled on each normal completion. Built only with DIV_RESULT_CACHE_EN.
module div_result_cache
  import div_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] lookup_rs1,
  input  logic [REG_W-1:0] lookup_rs2,
  input  logic [2:0]       lookup_op,
  output logic             hit,
  output logic [REG_W-1:0] hit_data,
  input  logic             upd,
  input  logic [REG_W-1:0] upd_rs1,
  input  logic [REG_W-1:0] upd_rs2,
  input  logic [2:0]       upd_op,
  input  logic [REG_W-1:0] upd_res,
  input  logic             inval
);

  cache_entry_t entry;

  assign hit      = entry.valid && (entry.rs1 == lookup_rs1) &&
                    (entry.rs2 == lookup_rs2) && (entry.op == lookup_op);
  assign hit_data = entry.res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry <= '0;
    end else if (inval) begin
      entry.valid <= 1'b0;
    end else if (upd) begin
      entry <= '{rs1: upd_rs1, rs2: upd_rs2, op: upd_op, res: upd_res, valid: 1'b1};
    end
  end

endmodule

// File: rtl/div_issue.sv
// EX-stage initiator for the iterative divider: issue, stall, watchdog and
// one-cycle write-back. Optional result cache under `DIV_RESULT_CACHE_EN.
//
// Divider handshake: div_start_o is held high for the whole divide and acts
// as a keep-alive; dropping it aborts the divider. div_ready_i is a single
// cycle completion pulse, and start is already low in that cycle so the
// divider never relatches the same operands.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [2:0]        funct3_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              div_start_o,
  output logic [REG_W-1:0]  div_dividend_o,
  output logic [REG_W-1:0]  div_divisor_o,
  output logic [2:0]        div_op_o,
  output logic [ADDR_W-1:0] div_waddr_o,
  input  logic [REG_W-1:0]  div_res_i,
  input  logic              div_ready_i,
  input  logic              div_busy_i,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [REG_W-1:0]  wb_data_o,
  output logic              err_o,
  output logic [2:0]        dbg_state,
  output logic              dbg_stray_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             issue, hit_take, complete, timeout;
  logic             cache_hit;
  logic [REG_W-1:0] cache_data;

`ifdef DIV_RESULT_CACHE_EN
  div_result_cache u_cache (
    .clk        (clk),
    .rst        (rst),
    .lookup_rs1 (rs1_i),
    .lookup_rs2 (rs2_i),
    .lookup_op  (funct3_i),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .upd        (complete),
    .upd_rs1    (div_dividend_o),
    .upd_rs2    (div_divisor_o),
    .upd_op     (div_op_o),
    .upd_res    (div_res_i),
    .inval      (timeout)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    div_start_o = 1'b0;
    issue       = 1'b0;
    hit_take    = 1'b0;
    complete    = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // rd==0 still holds EX for one cycle so DONE can release it cleanly.
        if (req_i && !flush_i && is_div_op(funct3_i)) begin
          stall_o = 1'b1;
          if (rd_i == '0) begin
            state_d = ST_DONE;
          end else if (cache_hit) begin
            hit_take = 1'b1;
            state_d  = ST_DONE;
          end else begin
            issue   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_start_o = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_op_o       <= '0;
      div_waddr_o    <= '0;
      wb_we_o        <= 1'b0;
      wb_waddr_o     <= '0;
      wb_data_o      <= '0;
      err_o          <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_we_o <= complete | hit_take;
      err_o   <= timeout;
      if (issue) begin
        div_dividend_o <= rs1_i;
        div_divisor_o  <= rs2_i;
        div_op_o       <= funct3_i;
        div_waddr_o    <= rd_i;
        cnt_q          <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (complete) begin
        wb_waddr_o <= div_waddr_o;
        wb_data_o  <= div_res_i;
      end else if (hit_take) begin
        wb_waddr_o <= rd_i;
        wb_data_o  <= cache_data;
      end
    end
  end

  assign dbg_state      = state_q;
  // The divider should never report busy while no divide is outstanding.
  assign dbg_stray_busy = div_busy_i && (state_q == ST_IDLE);

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue: table-driven divides through a small
// divider model, plus hand sequences for flush, rd=0, timeout and reset.
module tb_div_issue;

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_BUSY = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_i, flush_i, div_ready_i, div_busy_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i, div_res_i;
  logic [4:0]  rd_i;
  logic        stall_o, div_start_o, wb_we_o, err_o, dbg_stray_busy;
  logic [31:0] div_dividend_o, div_divisor_o, wb_data_o;
  logic [2:0]  div_op_o, dbg_state;
  logic [4:0]  div_waddr_o, wb_waddr_o;

  div_issue dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .funct3_i       (funct3_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_op_o       (div_op_o),
    .div_waddr_o    (div_waddr_o),
    .div_res_i      (div_res_i),
    .div_ready_i    (div_ready_i),
    .div_busy_i     (div_busy_i),
    .wb_we_o        (wb_we_o),
    .wb_waddr_o     (wb_waddr_o),
    .wb_data_o      (wb_data_o),
    .err_o          (err_o),
    .dbg_state      (dbg_state),
    .dbg_stray_busy (dbg_stray_busy)
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // divider model state
  bit          m_busy      = 1'b0;
  bit          never_ready = 1'b0;
  int          m_cnt       = 0;
  int          lat         = 3;
  int          n_starts    = 0;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Advance one clock; the divider model reacts to what the DUT drove
  // before the edge and presents its outputs just after it.
  task automatic step();
    logic       s;
    logic [2:0] op_s;
    logic [31:0] a_s, b_s;
    #1;
    s = div_start_o; op_s = div_op_o; a_s = div_dividend_o; b_s = div_divisor_o;
    @(posedge clk);
    #1;
    div_ready_i = 1'b0;
    div_res_i   = $urandom();
    if (m_busy) begin
      if (!s) m_busy = 1'b0;
      else if (m_cnt > 0) m_cnt--;
      if (m_busy && m_cnt == 0 && !never_ready) begin
        div_ready_i = 1'b1;
        div_res_i   = ref_div(m_op, m_a, m_b);
        m_busy      = 1'b0;
      end
    end else if (s) begin
      m_busy = 1'b1; m_cnt = lat; m_op = op_s; m_a = a_s; m_b = b_s;
      n_starts++;
    end
    div_busy_i = m_busy;
    #1;
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    req_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
  endtask

  task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string nm);
    int          s0;
    bit          seen;
    logic [31:0] e;
    s0 = n_starts;
    exp_q.push_back(exp);
    drive_req(f3, a, b, rd);
    #1;
    check({nm, "_stall_issue"}, stall_o, 1);
    check({nm, "_start_issue"}, div_start_o, 0);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      if (wb_we_o) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        check({nm, "_wb_data"}, wb_data_o, e);
        check({nm, "_wb_addr"}, wb_waddr_o, rd);
        check({nm, "_stall_release"}, stall_o, 0);
        check({nm, "_state_done"}, dbg_state, S_DONE);
        check({nm, "_start_done"}, div_start_o, 0);
      end else begin
        check({nm, "_stall_held"}, stall_o, 1);
        if (div_ready_i) check({nm, "_start_ready"}, div_start_o, 0);
      end
    end
    check({nm, "_wb_seen"}, seen, 1);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
    check({nm, "_lat_a"}, div_dividend_o, a);
    check({nm, "_lat_b"}, div_divisor_o, b);
    check({nm, "_lat_op"}, div_op_o, f3);
    check({nm, "_lat_rd"}, div_waddr_o, rd);
    step();
    req_i = 1'b0;
    #1;
    check({nm, "_wb_pulse"}, wb_we_o, 0);
    check({nm, "_state_idle"}, dbg_state, S_IDLE);
    check({nm, "_one_start"}, n_starts - s0, 1);
    check({nm, "_stray_busy"}, dbg_stray_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int s0;
    int busy_cycles;
    bit seen;

    vecs[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD};
    vecs[1] = '{OP_REM,  32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF};
    vecs[2] = '{OP_REMU, 32'd5,         32'd0,        5'd7,  32'h0000_0005};
    vecs[3] = '{OP_DIVU, 32'd100,       32'd7,        5'd8,  32'h0000_000E};
    vecs[4] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000};
    vecs[5] = '{OP_DIV,  32'd20,        32'd0,        5'd10, 32'hFFFF_FFFF};
    vecs[6] = '{OP_REMU, 32'hFFFF_FFFF, 32'd16,       5'd31, 32'h0000_000F};
    vecs[7] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd16,       5'd1,  32'h0FFF_FFFF};

    req_i = 0; funct3_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0; flush_i = 0;
    div_res_i = 0; div_ready_i = 0; div_busy_i = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_stall", stall_o, 0);
    check("rst_start", div_start_o, 0);
    check("rst_wb_we", wb_we_o, 0);
    check("rst_err", err_o, 0);
    check("rst_dividend", div_dividend_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    rst = 1'b1;
    step();

    // flush on BUSY cycle 10: start falls at once, no write-back
    lat = 30;
    drive_req(OP_DIVU, 32'd100, 32'd7, 5'd3);
    step();
    repeat (9) step();
    check("flush_state_busy", dbg_state, S_BUSY);
    check("flush_start_before", div_start_o, 1);
    flush_i = 1'b1;
    #1;
    check("flush_start_drop", div_start_o, 0);
    step();
    flush_i = 1'b0; req_i = 1'b0;
    #1;
    check("flush_state_idle", dbg_state, S_IDLE);
    check("flush_stall", stall_o, 0);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_wb", wb_we_o, 0);
      step();
    end
    lat = 3;

    // main table
    for (int i = 0; i < 8; i++) begin
      lat = 2 + i;
      run_div(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i));
    end
    lat = 3;

    // rd == 0: no issue, no write-back, stall for one cycle only
    s0 = n_starts;
    drive_req(OP_DIV, 32'd7, 32'd1, 5'd0);
    #1;
    check("rd0_stall", stall_o, 1);
    check("rd0_start", div_start_o, 0);
    step();
    check("rd0_state_done", dbg_state, S_DONE);
    check("rd0_stall_release", stall_o, 0);
    check("rd0_wb_done", wb_we_o, 0);
    req_i = 1'b0;
    step();
    check("rd0_state_idle", dbg_state, S_IDLE);
    check("rd0_wb_idle", wb_we_o, 0);
    check("rd0_no_start", n_starts - s0, 0);

    // ready and flush in the same cycle: flush wins
    lat = 4;
    drive_req(OP_DIV, 32'd9, 32'd3, 5'd11);
    step();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (div_ready_i) seen = 1'b1;
      else step();
    end
    check("rf_ready_seen", seen, 1);
    flush_i = 1'b1;
    #1;
    check("rf_start", div_start_o, 0);
    step();
    flush_i = 1'b0; req_i = 1'b0;
    #1;
    check("rf_no_wb", wb_we_o, 0);
    check("rf_state_idle", dbg_state, S_IDLE);
    step();
    check("rf_no_wb_late", wb_we_o, 0);
    lat = 3;

`ifdef DIV_RESULT_CACHE_EN
    // repeat of a cached divide completes without touching the divider
    run_div(OP_DIV, 32'd100, 32'd7, 5'd12, 32'h0000_000E, "cache_fill");
    s0 = n_starts;
    drive_req(OP_DIV, 32'd100, 32'd7, 5'd13);
    #1;
    check("cache_stall", stall_o, 1);
    check("cache_start_issue", div_start_o, 0);
    step();
    check("cache_wb_we", wb_we_o, 1);
    check("cache_wb_data", wb_data_o, 32'h0000_000E);
    check("cache_wb_addr", wb_waddr_o, 5'd13);
    check("cache_start_done", div_start_o, 0);
    req_i = 1'b0;
    step();
    check("cache_wb_pulse", wb_we_o, 0);
    check("cache_no_start", n_starts - s0, 0);
`endif

    // divider never answers: watchdog aborts after 64 BUSY cycles
    never_ready = 1'b1;
    drive_req(OP_DIVU, 32'd50, 32'd5, 5'd4);
    step();
    busy_cycles = 0;
    while (dbg_state == S_BUSY && busy_cycles < 200) begin
      busy_cycles++;
      if (busy_cycles == 64) check("tmo_start_drop", div_start_o, 0);
      else if (busy_cycles == 63) check("tmo_start_alive", div_start_o, 1);
      step();
    end
    req_i = 1'b0;
    #1;
    check("tmo_busy_cycles", busy_cycles, 64);
    check("tmo_err", err_o, 1);
    check("tmo_stall", stall_o, 0);
    check("tmo_no_wb", wb_we_o, 0);
    check("tmo_state_idle", dbg_state, S_IDLE);
    step();
    check("tmo_err_pulse", err_o, 0);
    never_ready = 1'b0;

    // asynchronous reset in the middle of a divide
    lat = 20;
    drive_req(OP_DIV, 32'd77, 32'd7, 5'd14);
    step();
    step();
    check("arst_busy", dbg_state, S_BUSY);
    req_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", dbg_state, S_IDLE);
    check("arst_start", div_start_o, 0);
    check("arst_dividend", div_dividend_o, 0);
    check("arst_waddr", div_waddr_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
